seg7_bank: RTL

- Multi-digit 7-segment display driver with registered outputs; the parametrised successor to the single-digit combinational encoder.
- Captures a packed nibble vector on a load strobe, decodes every digit, and optionally suppresses leading zeros and blinks selected digits.
- Sits between the application's status/counter logic and the board HEX displays (DE1-SoC: 6 digits, active-low segments).

---
 rtl/seg7_pkg.sv | 37 +++
 rtl/seg7_digit.sv | 18 +
 rtl/seg7_bank.sv | 113 +++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment types, constants and the per-nibble glyph lookup.
// Segment order is {g,f,e,d,c,b,a}, active low.
package seg7_pkg;

  typedef logic [6:0] seg7_t;
  typedef logic [3:0] nibble_t;

  localparam seg7_t SEG7_BLANK   = 7'h7F;
  localparam seg7_t SEG7_INVALID = 7'b1001001;

  function automatic seg7_t seg7_glyph(nibble_t nib, logic hex_en);
    seg7_t seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    if (!hex_en && nib >= 4'hA) begin
      seg = SEG7_INVALID;
    end
    return seg;
  endfunction

endpackage

// File: rtl/seg7_digit.sv
// Combinational single-digit decoder: glyph lookup with a forced-blank override.
module seg7_digit
  import seg7_pkg::*;
(
  input  nibble_t nib_i,
  input  logic    hex_en_i,
  input  logic    blank_i,
  output seg7_t   seg_o
);

  always_comb begin
    seg_o = seg7_glyph(nib_i, hex_en_i);
    if (blank_i) begin
      seg_o = SEG7_BLANK;
    end
  end

endmodule

// File: rtl/seg7_bank.sv
// Multi-digit registered 7-segment driver with leading-zero blanking.
// Optional blinking is built only when SEG7_BANK_BLINK_EN is defined.
module seg7_bank
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS    = 6,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic                  hex_en_i,
  input  logic                  blank_lz_i,
  input  logic [DIGITS-1:0]     blink_mask_i,
  output logic [7*DIGITS-1:0]   hex_o,
  output logic                  upd_o
);

  logic [4*DIGITS-1:0] value_q;
  logic                hex_en_q;
  logic                blank_lz_q;
  logic                loaded_q;   // stage 1 holds a real value (blank until first load)
  logic                pend_q;     // load captured last cycle, display update due
  logic [7*DIGITS-1:0] hex_q;
  logic                upd_q;

  logic [DIGITS-1:0]   lz_blank;
  logic                lz_run;
  logic [DIGITS-1:0]   blink_blank;
  logic [7*DIGITS-1:0] dec;
  logic [7*DIGITS-1:0] hex_d;

`ifdef SEG7_BANK_BLINK_EN
  localparam int unsigned CntW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CntW-1:0] cnt_q;
  logic            phase_q;
  logic            unused_blink;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (cnt_q == CntW'(BLINK_DIV - 1)) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  assign blink_blank  = phase_q ? blink_mask_i : '0;
  assign unused_blink = 1'b0;
`else
  logic unused_blink;

  assign blink_blank  = '0;
  assign unused_blink = ^blink_mask_i;
`endif

  // Scan from the most significant digit; digit 0 always shows.
  always_comb begin
    lz_blank = '0;
    lz_run   = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      lz_run      = lz_run & (value_q[4*k +: 4] == 4'h0);
      lz_blank[k] = blank_lz_q & lz_run;
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    seg7_digit u_digit (
      .nib_i    (value_q[4*k +: 4]),
      .hex_en_i (hex_en_q),
      .blank_i  (lz_blank[k] | blink_blank[k]),
      .seg_o    (dec[7*k +: 7])
    );
  end

  always_comb begin
    hex_d = '1;
    if (loaded_q) begin
      hex_d = dec;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q    <= '0;
      hex_en_q   <= 1'b0;
      blank_lz_q <= 1'b0;
      loaded_q   <= 1'b0;
      pend_q     <= 1'b0;
      hex_q      <= '1;
      upd_q      <= 1'b0;
    end else begin
      if (load_i) begin
        value_q    <= value_i;
        hex_en_q   <= hex_en_i;
        blank_lz_q <= blank_lz_i;
        loaded_q   <= 1'b1;
      end
      pend_q <= load_i;
      hex_q  <= hex_d;
      upd_q  <= pend_q;
    end
  end

  assign hex_o = hex_q;
  assign upd_o = upd_q;

endmodule
